// File: rtl/pwm_audio_out.sv
// pwm_audio_out: audio output stage for the piano mixer.
// Takes 8-bit samples over a valid/ready handshake, holds one sample and
// plays it for a full 256-cycle PWM period. A mute request ramps the duty
// to midscale one step per period so that muting does not click.
module pwm_audio_out #(
  parameter int unsigned RAMP_STEP = 4,
  parameter int unsigned MIDSCALE  = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sample,
  input  logic       sample_valid,
  output logic       sample_ready,
  input  logic       mute,
  output logic       pwm_out,
  output logic       period_tick,
  output logic       underrun
);

  localparam logic [7:0] MID   = 8'(MIDSCALE);
  localparam logic [8:0] MID9  = {1'b0, MID};
  localparam logic [8:0] STEP9 = 9'(RAMP_STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    RAMP  = 2'd2,
    MUTED = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] cnt;
  logic [7:0] duty;
  logic [7:0] duty_next;
  logic [7:0] hold;
  logic       hold_full;
  logic       boundary;
  logic       accept;
  logic       consume;
  logic       underrun_next;

  // Distance between a duty value and midscale; 9-bit so it never wraps.
  function automatic logic [8:0] mid_distance(input logic [7:0] d);
    logic [8:0] d9;
    d9 = {1'b0, d};
    if (d9 >= MID9) begin
      return d9 - MID9;
    end else begin
      return MID9 - d9;
    end
  endfunction

  // One ramp step toward midscale, landing exactly on midscale when close.
  function automatic logic [7:0] ramp_toward(input logic [7:0] d);
    logic [8:0] d9;
    d9 = {1'b0, d};
    if (mid_distance(d) <= STEP9) begin
      return MID;
    end else if (d9 > MID9) begin
      return 8'(d9 - STEP9);
    end else begin
      return 8'(d9 + STEP9);
    end
  endfunction

  assign boundary     = (cnt == 8'd255);
  assign sample_ready = !hold_full;
  assign accept       = sample_valid && !hold_full;

  // Free-running period counter, wraps 255 -> 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  // Holding register: filled on handshake, emptied by a boundary consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= 8'd0;
      hold_full <= 1'b0;
    end else if (consume) begin
      hold_full <= 1'b0;
    end else if (accept) begin
      hold      <= sample;
      hold_full <= 1'b1;
    end else begin
      hold_full <= hold_full;
    end
  end

  // FSM state and duty register; both only move on boundary cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      duty  <= MID;
    end else begin
      state <= state_next;
      duty  <= duty_next;
    end
  end

  // Next-state, next-duty, consume and underrun decisions at the boundary.
  always_comb begin
    state_next    = state;
    duty_next     = duty;
    consume       = 1'b0;
    underrun_next = 1'b0;
    if (boundary) begin
      case (state)
        IDLE: begin
          duty_next = MID;
          if (hold_full) begin
            consume = 1'b1;
            if (mute) begin
              state_next = MUTED;
            end else begin
              duty_next  = hold;
              state_next = PLAY;
            end
          end else begin
            state_next = IDLE;
          end
        end
        PLAY: begin
          if (mute) begin
            consume    = hold_full;
            duty_next  = ramp_toward(duty);
            state_next = RAMP;
          end else if (hold_full) begin
            consume   = 1'b1;
            duty_next = hold;
          end else begin
            underrun_next = 1'b1;
          end
        end
        RAMP: begin
          consume = hold_full;
          if (!mute) begin
            state_next = PLAY;
            if (hold_full) begin
              duty_next = hold;
            end else begin
              duty_next = duty;
            end
          end else if (mid_distance(duty) <= STEP9) begin
            duty_next  = MID;
            state_next = MUTED;
          end else begin
            duty_next = ramp_toward(duty);
          end
        end
        MUTED: begin
          duty_next = MID;
          consume   = hold_full;
          if (!mute) begin
            state_next = IDLE;
          end else begin
            state_next = MUTED;
          end
        end
        default: begin
          duty_next  = MID;
          state_next = IDLE;
        end
      endcase
    end else begin
      state_next = state;
    end
  end

  // Registered pin and status pulses; the pin lags the counter by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_out     <= 1'b0;
      period_tick <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      pwm_out     <= (cnt < duty);
      period_tick <= boundary;
      underrun    <= underrun_next;
    end
  end

endmodule

// File: tb/tb_pwm_audio_out.sv
// Directed bench for pwm_audio_out: measures high cycles per PWM period,
// underrun pulses and handshake stalls against hand-computed values.
module tb_pwm_audio_out;

  logic       clk;
  logic       rst;
  logic [7:0] sample;
  logic       sample_valid;
  logic       sample_ready;
  logic       mute;
  logic       pwm_out;
  logic       period_tick;
  logic       underrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] feed_q[$];
  bit         offered_ok = 1'b0;
  int         highs;
  int         urs;
  int         stalls;

  pwm_audio_out #(.RAMP_STEP(4), .MIDSCALE(128)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .mute         (mute),
    .pwm_out      (pwm_out),
    .period_tick  (period_tick),
    .underrun     (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the negedge on which period_tick is high.
  task automatic sync_period(input string tag);
    int n;
    n = 0;
    while (period_tick !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check(tag, int'(period_tick), 1);
  endtask

  // Run one PWM period (256 negedges, ending on the next period_tick),
  // feeding samples from feed_q and counting pin highs, underruns, stalls.
  task automatic run_period();
    highs  = 0;
    urs    = 0;
    stalls = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (sample_valid && offered_ok) begin
        void'(feed_q.pop_front());
        sample_valid = 1'b0;
      end
      if (feed_q.size() > 0) begin
        sample       = feed_q[0];
        sample_valid = 1'b1;
      end
      offered_ok = sample_ready;
      if (sample_valid && !sample_ready) stalls++;
      if (pwm_out) highs++;
      if (underrun) urs++;
    end
  endtask

  task automatic win(input string tag, input int exp_high, input int exp_ur);
    run_period();
    check({tag, "_high"}, highs, exp_high);
    check({tag, "_underrun"}, urs, exp_ur);
    check({tag, "_tick"}, int'(period_tick), 1);
  endtask

  initial begin
    rst          = 1'b1;
    sample       = 8'd0;
    sample_valid = 1'b0;
    mute         = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_tick", int'(period_tick), 0);
    check("rst_underrun", int'(underrun), 0);
    check("rst_ready", int'(sample_ready), 1);
    rst = 1'b0;

    // T1: mid-period reset drops the pin at once, then idle midscale
    sync_period("t1_sync0");
    repeat (10) @(negedge clk);
    check("t1_pwm_high_before_rst", int'(pwm_out), 1);
    #2;
    rst = 1'b1;
    #1;
    check("t1_pwm_async_rst", int'(pwm_out), 0);
    check("t1_ready_rst", int'(sample_ready), 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    sync_period("t1_sync1");
    win("t1_idle", 128, 0);

    // T2: play 0x40 then 0xC0
    feed_q.push_back(8'h40);
    win("t2_w0_idle", 128, 0);
    feed_q.push_back(8'hC0);
    win("t2_w1_0x40", 64, 0);

    // T3: three samples back-to-back; second waits for the boundary consume
    feed_q.push_back(8'h30);
    feed_q.push_back(8'h60);
    feed_q.push_back(8'h50);
    win("t3_w2_0xc0", 192, 0);
    check("t3_stalls", stalls, 254);
    win("t3_0x30", 48, 0);
    win("t3_0x60", 96, 0);

    // T4: source stops at duty 0x50 -> underrun each period, duty kept
    win("t4_0x50_a", 80, 1);
    win("t4_0x50_b", 80, 1);
    feed_q.push_back(8'h10);
    win("t4_0x50_c", 80, 0);
    feed_q.push_back(8'hF0);
    win("t4_0x10", 16, 0);

    // T5: mute ramp from 0xF0 down to midscale, incoming samples drained
    mute = 1'b1;
    win("t5_0xf0", 240, 0);
    feed_q.push_back(8'h11);
    feed_q.push_back(8'h22);
    feed_q.push_back(8'h33);
    for (int k = 1; k <= 29; k++) begin
      int exp_d;
      exp_d = 240 - 4 * k;
      if (exp_d < 128) exp_d = 128;
      win($sformatf("t5_ramp%0d", k), exp_d, 0);
    end
    check("t5_drained", feed_q.size(), 0);

    // T6: unmute, extremes, then mute released mid-ramp
    mute = 1'b0;
    win("t6_muted_exit", 128, 0);
    feed_q.push_back(8'h00);
    win("t6_idle", 128, 0);
    feed_q.push_back(8'hFF);
    win("t6_0x00", 0, 0);
    feed_q.push_back(8'hF0);
    win("t6_0xff", 255, 0);
    mute = 1'b1;
    win("t6_0xf0", 240, 0);
    win("t6_ramp_ec", 236, 0);
    mute = 1'b0;
    feed_q.push_back(8'h20);
    win("t6_ramp_e8", 232, 0);
    win("t6_unmuted_0x20", 32, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
